// File: rtl/l1_cache_pkg.sv
// rtl/l1_cache_pkg.sv - geometry constants, FSM encoding and line-address helper for l1_cache
package l1_cache_pkg;

    localparam int ADDR_W   = 16;
    localparam int WORD_W   = 16;
    localparam int TAG_W    = 9;
    localparam int IDX_W    = 3;
    localparam int WSEL_W   = 3;
    localparam int NSETS    = 8;
    localparam int LINE_W   = 128;

    localparam int TAG_LSB  = 7;
    localparam int IDX_LSB  = 4;
    localparam int WSEL_LSB = 1;

    typedef logic [1:0] state_t;

    localparam state_t IDLE      = 2'd0;
    localparam state_t WRITEBACK = 2'd1;
    localparam state_t FETCH     = 2'd2;

    // Line-aligned memory address; the byte-in-line bits are always zero.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_W-1:0] idx);
        return {tag, idx, 4'h0};
    endfunction

endpackage

// File: rtl/l1_cache_way.sv
// rtl/l1_cache_way.sv - one cache way: valid/dirty/tag/data arrays
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset (clears valid/dirty)
//   rd_idx_i             request set index; also the index for all writes
//   rd_valid_o/dirty_o/tag_o/data_o   combinational contents of set rd_idx_i
//   pk_idx_i             peek set index
//   pk_valid_o/pk_tag_o  combinational contents of set pk_idx_i
//   line_we_i/tag/data   full line fill: sets valid, clears dirty, loads tag
//   word_we_i/sel/data/be byte-masked word write, sets dirty
//   clr_dirty_i          clears dirty after the line has been written back
module l1_cache_way
    import l1_cache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic              rd_dirty_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_data_o,
    input  logic [IDX_W-1:0]  pk_idx_i,
    output logic              pk_valid_o,
    output logic [TAG_W-1:0]  pk_tag_o,
    input  logic              line_we_i,
    input  logic [TAG_W-1:0]  line_tag_i,
    input  logic [LINE_W-1:0] line_data_i,
    input  logic              word_we_i,
    input  logic [WSEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0] word_data_i,
    input  logic [1:0]        word_be_i,
    input  logic              clr_dirty_i
);

    logic [NSETS-1:0]  valid_q;
    logic [NSETS-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [NSETS];
    logic [LINE_W-1:0] data_q [NSETS];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];
    assign pk_valid_o = valid_q[pk_idx_i];
    assign pk_tag_o   = tag_q[pk_idx_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[rd_idx_i] <= 1'b1;
            dirty_q[rd_idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[rd_idx_i] <= 1'b1;
        end else if (clr_dirty_i) begin
            dirty_q[rd_idx_i] <= 1'b0;
        end
    end

    // Tag and data carry no reset; valid gates every use of them.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[rd_idx_i]  <= line_tag_i;
            data_q[rd_idx_i] <= line_data_i;
        end else if (word_we_i) begin
            if (word_be_i[0]) data_q[rd_idx_i][{word_sel_i, 4'h0} +: 8] <= word_data_i[7:0];
            if (word_be_i[1]) data_q[rd_idx_i][{word_sel_i, 4'h8} +: 8] <= word_data_i[15:8];
        end
    end

endmodule

// File: rtl/l1_cache.sv
// rtl/l1_cache.sv - 2-way, 8-set, write-back/write-allocate L1 cache with peek and lockout
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   mem_*                16-bit CPU port; mem_resp pulses combinationally on a hit
//   pmem_*               128-bit line port to memory (read = fetch, write = writeback)
//   lockout              when high in IDLE, a miss does not start a memory transaction
//   peek_address/hit     combinational residency probe, independent of FSM state
module l1_cache
    import l1_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_byte_enable,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic              lockout,
    input  logic [ADDR_W-1:0] peek_address,
    output logic              peek_hit
);

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_wsel;
    logic [TAG_W-1:0]  peek_tag;
    logic [IDX_W-1:0]  peek_idx;
    logic              unused_addr_bits;

    assign req_tag  = mem_address[ADDR_W-1:TAG_LSB];
    assign req_idx  = mem_address[TAG_LSB-1:IDX_LSB];
    assign req_wsel = mem_address[IDX_LSB-1:WSEL_LSB];
    assign peek_tag = peek_address[ADDR_W-1:TAG_LSB];
    assign peek_idx = peek_address[TAG_LSB-1:IDX_LSB];
    assign unused_addr_bits = ^{mem_address[0], peek_address[IDX_LSB-1:0]};

    state_t           state_q, state_d;
    logic             victim_q, victim_d;
    logic [NSETS-1:0] lru_q;

    logic [1:0]        rd_valid, rd_dirty, pk_valid;
    logic [TAG_W-1:0]  rd_tag [2];
    logic [TAG_W-1:0]  pk_tag [2];
    logic [LINE_W-1:0] rd_data [2];
    logic [1:0]        hit_way, peek_way, line_we, word_we, clr_dirty;

    logic              req, hit, serve, miss_start, lru_way, wb_done, fetch_done;
    logic [LINE_W-1:0] hit_line;

    for (genvar w = 0; w < 2; w++) begin : g_way
        l1_cache_way u_way (
            .clk_i       (clk),
            .rst_i       (rst),
            .rd_idx_i    (req_idx),
            .rd_valid_o  (rd_valid[w]),
            .rd_dirty_o  (rd_dirty[w]),
            .rd_tag_o    (rd_tag[w]),
            .rd_data_o   (rd_data[w]),
            .pk_idx_i    (peek_idx),
            .pk_valid_o  (pk_valid[w]),
            .pk_tag_o    (pk_tag[w]),
            .line_we_i   (line_we[w]),
            .line_tag_i  (req_tag),
            .line_data_i (pmem_rdata),
            .word_we_i   (word_we[w]),
            .word_sel_i  (req_wsel),
            .word_data_i (mem_wdata),
            .word_be_i   (mem_byte_enable),
            .clr_dirty_i (clr_dirty[w])
        );
        assign hit_way[w]  = rd_valid[w] && (rd_tag[w] == req_tag);
        assign peek_way[w] = pk_valid[w] && (pk_tag[w] == peek_tag);
    end

    assign req      = mem_read || mem_write;
    assign hit      = |hit_way;
    assign hit_line = hit_way[1] ? rd_data[1] : rd_data[0];
    assign lru_way  = lru_q[req_idx];

    // Hits are served only from IDLE; a miss waits for the refill and then hits.
    assign serve      = (state_q == IDLE) && req && hit && !rst;
    assign miss_start = (state_q == IDLE) && req && !hit && !lockout;
    assign wb_done    = (state_q == WRITEBACK) && pmem_resp;
    assign fetch_done = (state_q == FETCH) && pmem_resp;

    assign mem_resp  = serve;
    assign mem_rdata = hit_line[{req_wsel, 4'h0} +: WORD_W];

    // A simultaneous read and write is handled as a write.
    assign word_we   = {serve && mem_write && hit_way[1], serve && mem_write && hit_way[0]};
    assign line_we   = {fetch_done && victim_q, fetch_done && !victim_q};
    assign clr_dirty = {wb_done && victim_q, wb_done && !victim_q};

    assign pmem_write   = (state_q == WRITEBACK);
    assign pmem_read    = (state_q == FETCH);
    assign pmem_address = (state_q == WRITEBACK) ? line_addr(rd_tag[victim_q], req_idx)
                                                 : line_addr(req_tag, req_idx);
    assign pmem_wdata   = rd_data[victim_q];

    assign peek_hit = |peek_way;

    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        case (state_q)
            IDLE: begin
                if (miss_start) begin
                    // Latch the victim so WRITEBACK and FETCH agree on the way.
                    victim_d = lru_way;
                    state_d  = (rd_valid[lru_way] && rd_dirty[lru_way]) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: if (pmem_resp) state_d = FETCH;
            FETCH:     if (pmem_resp) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            // LRU bit names the way to evict next: the one not just used.
            if (serve) lru_q[req_idx] <= hit_way[0];
        end
    end

endmodule

// File: tb/tb_l1_cache.sv
// tb/tb_l1_cache.sv - directed self-checking bench for l1_cache
module tb_l1_cache;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  mem_address = '0;
    logic [15:0]  mem_wdata = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [1:0]   mem_byte_enable = '0;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;
    logic         lockout = 1'b0;
    logic [15:0]  peek_address = '0;
    logic         peek_hit;

    l1_cache dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .lockout         (lockout),
        .peek_address    (peek_address),
        .peek_hit        (peek_hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] mem_model [logic [15:0]];

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
    } ev_t;
    ev_t events[$];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [1:0]  be;
        logic [15:0] peek;
        logic [15:0] exp_rdata;
        bit          exp_peek;
    } vec_t;
    vec_t vecs[13];

    function automatic logic [127:0] default_line(input logic [15:0] a);
        logic [127:0] l;
        for (int k = 0; k < 8; k++) l[k*16 +: 16] = {a[15:4], 4'(k)};
        return l;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts and ends just after a rising edge; serves memory from mem_model.
    task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [1:0] be,
                          output logic [15:0] rdata, output int cyc);
        bit done;
        done = 0;
        cyc = 0;
        rdata = 'x;
        mem_read = rd;
        mem_write = wr;
        mem_address = addr;
        mem_wdata = wd;
        mem_byte_enable = be;
        while (!done) begin
            @(negedge clk);
            if (pmem_read && pmem_write) chk("pmem_exclusive", 1'b1, 1'b0);
            if (mem_resp) begin
                rdata = mem_rdata;
                done = 1;
            end else if (pmem_write) begin
                mem_model[pmem_address] = pmem_wdata;
                events.push_back('{is_wr: 1'b1, addr: pmem_address});
                pmem_resp = 1'b1;
                @(posedge clk);
                #1 pmem_resp = 1'b0;
                cyc++;
            end else if (pmem_read) begin
                pmem_rdata = mem_model.exists(pmem_address) ? mem_model[pmem_address]
                                                            : default_line(pmem_address);
                events.push_back('{is_wr: 1'b0, addr: pmem_address});
                pmem_resp = 1'b1;
                @(posedge clk);
                #1 pmem_resp = 1'b0;
                cyc++;
            end else begin
                cyc++;
                if (cyc > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL access_timeout: addr %h no response after %0d cycles", addr, cyc);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        lockout = 1'b0;
        pmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rdata;
        int          cyc;
        bit          seen;

        mem_model[16'h1230] = 128'h7777_6666_5555_4444_3333_BEEF_1111_0000;

        vecs[0]  = '{1, 0, 16'h1234, 16'h0000, 2'b00, 16'h123F, 16'hBEEF, 1};
        vecs[1]  = '{0, 1, 16'h1234, 16'hAA55, 2'b01, 16'h1240, 16'h0000, 0};
        vecs[2]  = '{1, 0, 16'h1234, 16'h0000, 2'b00, 16'h1230, 16'hBE55, 1};
        vecs[3]  = '{1, 0, 16'h1230, 16'h0000, 2'b00, 16'h0230, 16'h0000, 0};
        vecs[4]  = '{0, 1, 16'h1236, 16'h12C4, 2'b10, 16'h123F, 16'h0000, 1};
        vecs[5]  = '{1, 0, 16'h1237, 16'h0000, 2'b00, 16'h1231, 16'h1233, 1};
        vecs[6]  = '{0, 1, 16'h123E, 16'hCAFE, 2'b11, 16'h2230, 16'h0000, 0};
        vecs[7]  = '{1, 0, 16'h123E, 16'h0000, 2'b00, 16'h123F, 16'hCAFE, 1};
        vecs[8]  = '{0, 1, 16'h123C, 16'hFFFF, 2'b00, 16'h1240, 16'h0000, 0};
        vecs[9]  = '{1, 0, 16'h123C, 16'h0000, 2'b00, 16'h123F, 16'h6666, 1};
        vecs[10] = '{1, 1, 16'h1232, 16'h5A5A, 2'b11, 16'h123F, 16'h0000, 1};
        vecs[11] = '{1, 0, 16'h1232, 16'h0000, 2'b00, 16'h123F, 16'h5A5A, 1};
        vecs[12] = '{1, 0, 16'h123A, 16'h0000, 2'b00, 16'h123F, 16'h5555, 1};

        // Reset state
        rst = 1'b1;
        mem_read = 1'b1;
        mem_address = 16'h1234;
        peek_address = 16'h1230;
        @(negedge clk);
        chk("reset_mem_resp", mem_resp, 1'b0);
        do_reset();
        @(negedge clk);
        chk("reset_pmem_read", pmem_read, 1'b0);
        chk("reset_pmem_write", pmem_write, 1'b0);
        chk("reset_peek", peek_hit, 1'b0);
        @(posedge clk);
        #1;

        // Cold read miss
        events.delete();
        access(1, 0, 16'h1234, 16'h0, 2'b00, rdata, cyc);
        chk("cold_rdata", rdata, 16'hBEEF);
        chk("cold_latency", cyc, 2);
        chk("cold_events", events.size(), 1);
        if (events.size() == 1) begin
            chk("cold_is_read", events[0].is_wr, 1'b0);
            chk("cold_addr", events[0].addr, 16'h1230);
        end

        // Hit table: zero-latency reads/writes on the resident line plus peeks
        events.delete();
        for (int i = 0; i < 13; i++) begin
            peek_address = vecs[i].peek;
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be, rdata, cyc);
            chk($sformatf("vec%0d_latency", i), cyc, 0);
            if (vecs[i].rd && !vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_peek", i), peek_hit, vecs[i].exp_peek);
        end
        chk("hits_no_pmem", events.size(), 0);

        // Dirty eviction in set 3
        do_reset();
        access(1, 0, 16'h0030, 16'h0, 2'b00, rdata, cyc);
        access(1, 0, 16'h00B0, 16'h0, 2'b00, rdata, cyc);
        access(0, 1, 16'h0030, 16'hD00D, 2'b11, rdata, cyc);
        access(1, 0, 16'h00B0, 16'h0, 2'b00, rdata, cyc);
        events.delete();
        access(1, 0, 16'h0130, 16'h0, 2'b00, rdata, cyc);
        chk("evict_latency", cyc, 3);
        chk("evict_rdata", rdata, 16'h0130);
        chk("evict_events", events.size(), 2);
        if (events.size() == 2) begin
            chk("evict_first_is_write", events[0].is_wr, 1'b1);
            chk("evict_wb_addr", events[0].addr, 16'h0030);
            chk("evict_second_is_read", events[1].is_wr, 1'b0);
            chk("evict_fetch_addr", events[1].addr, 16'h0130);
        end
        chk("evict_wb_data", mem_model[16'h0030], 128'h0037_0036_0035_0034_0033_0032_0031_D00D);
        access(1, 0, 16'h00B2, 16'h0, 2'b00, rdata, cyc);
        chk("survivor_latency", cyc, 0);
        chk("survivor_rdata", rdata, 16'h00B1);
        events.delete();
        access(1, 0, 16'h0030, 16'h0, 2'b00, rdata, cyc);
        chk("refetch_latency", cyc, 2);
        chk("refetch_rdata", rdata, 16'hD00D);

        // Lockout holds off the fetch while hits continue
        do_reset();
        access(1, 0, 16'h1234, 16'h0, 2'b00, rdata, cyc);
        lockout = 1'b1;
        mem_read = 1'b1;
        mem_address = 16'h4444;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen |= pmem_read | pmem_write | mem_resp;
        end
        chk("lockout_no_traffic", seen, 1'b0);
        @(posedge clk);
        #1 mem_address = 16'h1234;
        @(negedge clk);
        chk("lockout_hit_resp", mem_resp, 1'b1);
        chk("lockout_hit_rdata", mem_rdata, 16'hBEEF);
        @(posedge clk);
        #1;
        mem_address = 16'h4444;
        lockout = 1'b0;
        peek_address = 16'h123F;
        @(negedge clk);
        chk("unlock_same_cycle", pmem_read, 1'b0);
        @(negedge clk);
        chk("unlock_fetch", pmem_read, 1'b1);
        chk("unlock_fetch_addr", pmem_address, 16'h4440);
        chk("peek_in_fetch_hit", peek_hit, 1'b1);
        peek_address = 16'h1240;
        #1;
        chk("peek_in_fetch_miss", peek_hit, 1'b0);
        pmem_rdata = default_line(16'h4440);
        pmem_resp = 1'b1;
        @(posedge clk);
        #1 pmem_resp = 1'b0;
        @(negedge clk);
        chk("unlock_resp", mem_resp, 1'b1);
        chk("unlock_rdata", mem_rdata, 16'h4442);
        @(posedge clk);
        #1 mem_read = 1'b0;

        // Reset in the middle of a fetch
        mem_read = 1'b1;
        mem_address = 16'h5554;
        @(negedge clk);
        @(negedge clk);
        chk("midfetch_pmem_read", pmem_read, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_read = 1'b0;
        peek_address = 16'h123F;
        @(negedge clk);
        chk("post_reset_pmem_read", pmem_read, 1'b0);
        chk("post_reset_pmem_write", pmem_write, 1'b0);
        chk("post_reset_peek", peek_hit, 1'b0);
        @(posedge clk);
        #1;
        events.delete();
        access(1, 0, 16'h1234, 16'h0, 2'b00, rdata, cyc);
        chk("post_reset_miss_latency", cyc, 2);
        chk("post_reset_events", events.size(), 1);
        if (events.size() == 1) chk("post_reset_fetch_addr", events[0].addr, 16'h1230);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l1_cache.md
Name: l1_cache

Overview:
- Unified L1 cache between the 16-bit CPU memory port and a 128-bit line-wide physical memory port.
- Organisation: 2-way set-associative, 8 sets, 16-byte lines, write-back, write-allocate, LRU replacement.
- Adds a combinational peek port and a lockout input so an external prefetch wrapper can test line residency and hold off new memory traffic.

Parameters:
- none; all geometry constants live in l1_cache_pkg.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- mem_address  in  16  CPU byte address
- mem_wdata  in  16  CPU write word
- mem_read  in  1  CPU read request (level, held until mem_resp)
- mem_write  in  1  CPU write request (level, held until mem_resp)
- mem_byte_enable  in  2  byte lanes for writes (bit0 = low byte)
- mem_rdata  out  16  read word, valid when mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_rdata  in  128  line from memory
- pmem_resp  in  1  memory completion
- pmem_address  out  16  line address, low 4 bits always 0
- pmem_wdata  out  128  victim line for writeback
- pmem_read  out  1  line fetch request
- pmem_write  out  1  line writeback request
- lockout  in  1  forbid starting a new pmem transaction
- peek_address  in  16  address for residency probe
- peek_hit  out  1  probe result

Behaviour:
- Address fields: tag[15:7] (9 bits), index[6:4], word[3:1], byte[0] ignored for reads.
- Per way/set storage: valid, dirty, tag, 128-bit data; one LRU bit per set.
- Reset: valid, dirty and LRU cleared; FSM to IDLE; mem_resp=0, pmem_read=0, pmem_write=0. Reset mid-transaction aborts it; pmem_read/write drop on the next cycle and dirty data is discarded.
- FSM states: IDLE, WRITEBACK, FETCH.
- IDLE, read or write hit:
  - mem_resp=1 combinationally in the same cycle, so hit latency is 0 cycles after request.
  - mem_rdata = word[3:1] of the hit line.
  - Write hit merges mem_wdata per mem_byte_enable and sets dirty.
  - On the clock edge, LRU points to the other way.
- IDLE, miss with lockout=0:
  - If the LRU victim is valid and dirty, go to WRITEBACK; otherwise go to FETCH.
  - mem_resp stays 0.
- IDLE, miss with lockout=1: remain in IDLE, no pmem request. Hits are still served under lockout.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag, index, 4'h0}, pmem_wdata=victim data.
  - On pmem_resp, clear victim dirty and go to FETCH.
- FETCH:
  - pmem_read=1, pmem_address={req tag, index, 4'h0}.
  - On pmem_resp, write pmem_rdata into the victim way, set valid, clear dirty, set tag, and return to IDLE.
  - The request then hits on the next cycle, so miss latency is writeback + fetch + 1 cycle.
- lockout is sampled only in IDLE; a started WRITEBACK/FETCH always completes.
- pmem_read and pmem_write are never high together. pmem_address and pmem_wdata are held stable while the request is high.
- mem_read and mem_write both high: treated as a write.
- No request: mem_resp=0; no state or LRU change.
- peek_hit: purely combinational and state-independent; 1 if either way of index(peek_address) is valid with matching tag.
- pmem_resp is ignored outside WRITEBACK/FETCH.

Decomposition:
- l1_cache_pkg: field widths/positions (TAG_W=9, IDX_W=3, NSETS=8, LINE_W=128), line-address helper, state enum {IDLE, WRITEBACK, FETCH}.
- One sub-module, l1_cache_way: a single way holding valid/dirty/tag/data arrays.
  - Reads: combinational, with two read ports (request index, peek index).
  - Writes: synchronous line write and byte-masked word write.
  - Instantiated twice; hit logic, LRU and control sit in l1_cache.

Test Plan:
- Cold read miss: read 0x1234 after reset.
  - Expect pmem_read with pmem_address=0x1230 and no pmem_write.
  - Return pmem_rdata with word 2 = 0xBEEF; mem_resp=1 next cycle with mem_rdata=0xBEEF.
- Write hit, byte lane: write 0x1234 data=0xAA55 be=2'b01, then read.
  - Expect 0xBE55 with a 0-cycle response; line is now dirty.
- Dirty eviction: fill set 3 via 0x0030 and 0x00B0, dirty 0x0030, touch 0x00B0, read 0x0130.
  - Expect pmem_write to 0x0030 carrying the modified line, then pmem_read 0x0130.
- Lockout: assert lockout, then read a missing address.
  - No pmem_read for 10 cycles, while a hit to a resident line still responds.
  - Deassert lockout; the fetch starts next cycle.
- Peek: with 0x1230 resident, peek 0x123F gives peek_hit=1 and peek 0x1240 gives 0, including while in FETCH.
- Reset mid-FETCH: assert rst while pmem_read=1.
  - pmem_read=0 next cycle; a prior hit address now misses.
